// File: rtl/riscv_pkg.sv
// Shared RV32I core types: register-file geometry and x0 address.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 mask plus optional write-through
// forwarding when built with REGFILE_BYPASS_EN.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::REG_AW
) (
  input  logic [AW-1:0]                 raddr_i,
  input  logic [2**AW-1:0][XLEN-1:0]    regs_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                          rst_i,
  input  logic                          we_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic [XLEN-1:0]               wdata_i,
`endif
  output logic [XLEN-1:0]               rdata_o
);

  logic is_zero;

  assign is_zero = (raddr_i == AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic fwd;

  assign fwd = !rst_i && we_i
            && (waddr_i != AW'(REG_ZERO))
            && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      is_zero: rdata_o = '0;
      fwd:     rdata_o = wdata_i;
      default: rdata_o = regs_i[raddr_i];
    endcase
  end
`else
  always_comb begin
    rdata_o = '0;
    if (!is_zero) rdata_o = regs_i[raddr_i];
  end
`endif

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: 2 async read ports, 1 sync write port.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int NREG = 2**AW;

  // x0 has no flops; it only appears as a zero slot in the read view.
  logic [NREG-1:1][XLEN-1:0] regs_q;
  logic [NREG-1:1][XLEN-1:0] regs_d;
  logic [NREG-1:0][XLEN-1:0] view;

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      regs_d = '0;
    end else if (we && (rd != AW'(REG_ZERO))) begin
      regs_d[rd] = wd;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign view = {regs_q, {XLEN{1'b0}}};

  regfile_read_port #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_rp1 (
    .raddr_i (rs1),
    .regs_i  (view),
`ifdef REGFILE_BYPASS_EN
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (rd),
    .wdata_i (wd),
`endif
    .rdata_o (rd1)
  );

  regfile_read_port #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_rp2 (
    .raddr_i (rs2),
    .regs_i  (view),
`ifdef REGFILE_BYPASS_EN
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (rd),
    .wdata_i (wd),
`endif
    .rdata_o (rd2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile (either bypass build).
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] wd;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .rs1 (rs1),
    .rs2 (rs2),
    .rd  (rd),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] e1, e2;
    rst = 1'b1; we = 1'b0;
    rs1 = 5'd5; rs2 = 5'd31; rd = 5'd0; wd = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_rd2", rd2, 32'd0);

    // basic write/read
    we = 1'b1; rd = 5'd1; wd = 32'd42;
    tick();
    rd = 5'd2; wd = 32'd99;
    tick();
    we = 1'b0; rs1 = 5'd1; rs2 = 5'd2;
    #1;
    chk("basic_x1", rd1, 32'd42);
    chk("basic_x2", rd2, 32'd99);

    // x0 hardwired
    we = 1'b1; rd = 5'd0; wd = 32'hDEADBEEF;
    rs1 = 5'd0; rs2 = 5'd1;
    #1;
    chk("x0_same_cycle", rd1, 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("x0_after", rd1, 32'd0);
    chk("x0_x1_kept", rd2, 32'd42);

    // write disable
    we = 1'b0; rd = 5'd1; wd = 32'd5; rs1 = 5'd1;
    tick(); tick(); tick();
    chk("we0_x1", rd1, 32'd42);

    // reset clears
    we = 1'b1; rd = 5'd5; wd = 32'h1234;
    tick();
    rd = 5'd31; wd = 32'hFFFFFFFF;
    tick();
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    #1;
    chk("pre_rst_x5", rd1, 32'h1234);
    chk("pre_rst_x31", rd2, 32'hFFFFFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_x5", rd1, 32'd0);
    chk("rst_x31", rd2, 32'd0);

    // reset beats write, no forwarding under reset
    rst = 1'b1; we = 1'b1; rd = 5'd3; wd = 32'd7; rs1 = 5'd3;
    #1;
    chk("rst_nofwd", rd1, 32'd0);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst_wr_drop", rd1, 32'd0);

    // read during write
    we = 1'b1; rd = 5'd7; wd = 32'h11;
    tick();
    wd = 32'h22; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    e1 = BYP ? 32'h22 : 32'h11;
    chk("rdw_before_rd1", rd1, e1);
    chk("rdw_before_rd2", rd2, e1);
    tick();
    we = 1'b0;
    #1;
    chk("rdw_after_rd1", rd1, 32'h22);
    chk("rdw_after_rd2", rd2, 32'h22);

    // address sweep
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); wd = 32'(i * 3);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      e1 = (i == 0) ? 32'd0 : 32'(i * 3);
      e2 = (i == 31) ? 32'd0 : 32'((31 - i) * 3);
      chk($sformatf("sweep_rd1_x%0d", i), rd1, e1);
      chk($sformatf("sweep_rd2_x%0d", 31 - i), rd2, e2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
